// File: rtl/puf_pkg.sv
// Shared definitions for the PUF authentication sequencer.
//   CHAL_W / RESP_W : challenge and response widths of the arbiter PUF wrapper
//   LFSR_TAPS       : feedback taps of x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   puf_state_e     : sequencer FSM states
//   popcount8       : number of set bits in a byte (0..8)
//   lfsr_next       : one Fibonacci LFSR step, shifting left
package puf_pkg;

  localparam int unsigned CHAL_W = 8;
  localparam int unsigned RESP_W = 8;

  localparam logic [CHAL_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StWaitExp,
    StFinish
  } puf_state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // Feedback is the XOR of the tapped bits; new bit enters at the LSB.
  function automatic logic [CHAL_W-1:0] lfsr_next(input logic [CHAL_W-1:0] s);
    return {s[CHAL_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/puf_auth_sequencer_if.sv
// Bus bundle between the authentication sequencer and its environment.
//   master : drives start/abort/seed, the PUF response and the expected-response stream
//   slave  : the sequencer; drives the challenge, exp_ready, status and verdict
// HD_W must equal $clog2(8*N_CHAL+1) of the connected sequencer.
interface puf_auth_sequencer_if
  import puf_pkg::*;
#(
  parameter int unsigned HD_W = 8
) ();

  logic              start;
  logic              abort;
  logic [CHAL_W-1:0] seed;
  logic [CHAL_W-1:0] chal_out;
  logic [RESP_W-1:0] resp_in;
  logic              exp_valid;
  logic [RESP_W-1:0] exp_resp;
  logic              exp_ready;
  logic              busy;
  logic              done;
  logic              pass;
  logic [HD_W-1:0]   hd_total;

  modport master (
    output start, abort, seed, resp_in, exp_valid, exp_resp,
    input  chal_out, exp_ready, busy, done, pass, hd_total
  );

  modport slave (
    input  start, abort, seed, resp_in, exp_valid, exp_resp,
    output chal_out, exp_ready, busy, done, pass, hd_total
  );

endinterface

// File: rtl/puf_lfsr8.sv
// 8-bit maximal-length challenge generator.
//   clk, rst_n : clock, asynchronous active-low reset (value resets to 0x00)
//   load       : capture seed; a zero seed is replaced by 0x01 so the LFSR never locks up
//   seed       : initial challenge
//   step       : advance one LFSR step (ignored while load is high)
//   value      : current challenge
module puf_lfsr8
  import puf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [CHAL_W-1:0] seed,
  input  logic              step,
  output logic [CHAL_W-1:0] value
);

  logic [CHAL_W-1:0] value_q;
  logic [CHAL_W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = (seed == '0) ? CHAL_W'(1) : seed;
    end else if (step) begin
      value_d = lfsr_next(value_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/puf_auth_sequencer.sv
// PUF authentication sequencer.
// Drives LFSR challenges to the arbiter PUF, waits SETTLE_CYCLES for the arbiter to
// resolve, samples the response, compares it against the enrollment stream and
// accumulates the Hamming distance over N_CHAL challenges, then issues a verdict.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : start/abort/seed in; chal_out/resp_in PUF side; exp_valid/exp_resp/exp_ready
//                enrollment stream; busy/done/pass/hd_total status and verdict
module puf_auth_sequencer
  import puf_pkg::*;
#(
  parameter int unsigned N_CHAL        = 16,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned HD_THRESH     = 12
) (
  input logic                  clk,
  input logic                  rst_n,
  puf_auth_sequencer_if.slave  bus
);

  localparam int unsigned HD_W  = $clog2(8 * N_CHAL + 1);
  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES);
  localparam int unsigned IDX_W = $clog2(N_CHAL);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CHAL - 1);

  puf_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [HD_W-1:0]   hd_q, hd_d;
  logic [RESP_W-1:0] resp_q, resp_d;
  logic              pass_q, pass_d;
  logic              done_q, done_d;
  logic              lfsr_load;
  logic              lfsr_step;
  logic              exp_hs;
  logic [CHAL_W-1:0] chal;

  assign exp_hs = bus.exp_valid && (state_q == StWaitExp);

  puf_lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (bus.seed),
    .step  (lfsr_step),
    .value (chal)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    hd_d      = hd_q;
    resp_d    = resp_q;
    pass_d    = pass_q;
    done_d    = 1'b0;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    if (bus.abort) begin
      // Abort beats start in IDLE and any handshake elsewhere; partial hd_total is kept.
      state_d = StIdle;
      if (state_q != StIdle) begin
        pass_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            lfsr_load = 1'b1;
            cnt_d     = '0;
            idx_d     = '0;
            hd_d      = '0;
            pass_d    = 1'b0;
            state_d   = StSettle;
          end
        end
        StSettle: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            resp_d  = bus.resp_in;
            state_d = StWaitExp;
          end
        end
        StWaitExp: begin
          if (exp_hs) begin
            hd_d = hd_q + HD_W'(popcount8(resp_q ^ bus.exp_resp));
            if (idx_q == IDX_LAST) begin
              state_d = StFinish;
            end else begin
              idx_d     = idx_q + 1'b1;
              cnt_d     = '0;
              lfsr_step = 1'b1;
              state_d   = StSettle;
            end
          end
        end
        StFinish: begin
          pass_d  = (32'(hd_q) <= HD_THRESH);
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      hd_q    <= '0;
      resp_q  <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hd_q    <= hd_d;
      resp_q  <= resp_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  assign bus.chal_out  = chal;
  assign bus.exp_ready = (state_q == StWaitExp);
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.hd_total  = hd_q;

endmodule
